// File: rtl/ram_scan_reader_pkg.sv
// Shared definitions for the RAM scan reader: FSM state encoding and default geometry.
package ram_scan_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_READ_LATENCY = 1;
  localparam int RAM_DEPTH        = 1 << DEF_ADDR_W;

endpackage

// File: rtl/ram_scan_addr_ctr.sv
// Loadable wrapping address counter that drives the RAM read address during a scan.
module ram_scan_addr_ctr #(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              at_last
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Incrementing past the top address wraps to 0 by natural overflow.
  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_addr;
    end else if (inc) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr    = addr_q;
  assign at_last = (addr_q == last_addr);

endmodule

// File: rtl/ram_scan_reader.sv
// Sequential read-back engine for the lab LPM RAM with a valid/ready word output.
// Define RAM_SCAN_READER_CHECKSUM_EN to build the running checksum; otherwise it reads 0.
module ram_scan_reader
  import ram_scan_reader_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int CNT_W = $clog2(READ_LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_valid_q, out_valid_d;
  logic              ctr_load, ctr_inc, at_last;

  ram_scan_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clock     (clock),
    .resetn    (resetn),
    .load      (ctr_load),
    .load_addr (first_addr),
    .inc       (ctr_inc),
    .last_addr (last_q),
    .addr      (ram_addr),
    .at_last   (at_last)
  );

  // WAIT spends READ_LATENCY+1 edges so ram_q has settled for the held address.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    ctr_load    = 1'b0;
    ctr_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d   = last_addr;
          ctr_load = 1'b1;
          cnt_d    = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          out_data_d  = ram_q;
          out_addr_d  = ram_addr;
          out_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (at_last) begin
            state_d = ST_DONE;
          end else begin
            ctr_inc = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef RAM_SCAN_READER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Sum wraps at DATA_W bits; the presented word is added on its handshake.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == ST_IDLE && start) begin
      checksum_d = '0;
    end else if (state_q == ST_PRESENT && out_ready) begin
      checksum_d = checksum_q + out_data_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: doc/ram_scan_reader.md
# ram_scan_reader

Sequential read-back engine for the 32×8 synchronous LPM RAM used in the lab datapath. It owns the RAM address port during a scan and walks an inclusive address range, wrapping past the top address if needed. It waits out the RAM read latency, then presents each word with its address on a valid/ready output. It is the read side of the switch-driven write path: the board top muxes `ram_addr` onto the RAM when `busy` is high and feeds `out_data`/`out_addr` to the seven-segment decoders.

## Interface
- `ADDR_W`, 5, RAM address width (depth 2^ADDR_W).
- `DATA_W`, 8, RAM word width.
- `READ_LATENCY`, 1, rising edges from a stable `ram_addr` to a valid `ram_q`; must be ≥1.

- `clock` in 1: single clock, rising edge.
- `resetn` in 1: reset, **asynchronous, active-low**.
- `start` in 1: begin a scan; sampled only in IDLE.
- `first_addr` in ADDR_W: first address; captured at start.
- `last_addr` in ADDR_W: last address, inclusive; captured at start.
- `ram_addr` out ADDR_W: registered RAM read address.
- `ram_q` in DATA_W: RAM read data.
- `out_data` out DATA_W: presented word.
- `out_addr` out ADDR_W: address of `out_data`.
- `out_valid` out 1: word available.
- `out_ready` in 1: consumer accepts the word.
- `busy` out 1: scan in progress (any state other than IDLE).
- `done` out 1: one-cycle pulse after the last word is accepted.
- `checksum` out DATA_W: running sum of the scan's accepted words.

## Operation
- States: IDLE, WAIT, PRESENT, DONE.
- IDLE: `busy`=0. When `start`=1, capture `first_addr`/`last_addr`, set `ram_addr`←`first_addr`, clear `checksum` and the latency counter, and go to WAIT.
- WAIT: hold `ram_addr`. Count READ_LATENCY+1 edges. On the final edge, load `out_data`←`ram_q` and `out_addr`←`ram_addr`, set `out_valid`←1, and go to PRESENT.
- PRESENT: hold `out_valid`, `out_data` and `out_addr` stable until `out_ready`=1 at a rising edge (the handshake). On the handshake:
  - clear `out_valid`;
  - add `out_data` to `checksum`;
  - if `ram_addr`==captured last, go to DONE;
  - otherwise `ram_addr`←`ram_addr`+1 mod 2^ADDR_W, clear the counter, and go to WAIT.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `checksum` holds its value until the next start.
- Range rules:
  - `first`==`last` reads exactly one word.
  - `first`>`last` wraps through 2^ADDR_W−1 to 0 and ends at `last`.
  - Words per scan = ((last−first) mod 2^ADDR_W)+1.
- `start` while `busy` is ignored. `first_addr`/`last_addr` changes during a scan have no effect.
- `out_ready` high outside PRESENT is ignored. `out_valid` never drops without a handshake.
- Checksum arithmetic: DATA_W-bit, carries discarded.

## Timing
- Reset (asynchronous, any state including mid-scan): state IDLE. `ram_addr`, `out_data`, `out_addr`, `checksum`, the counter and all flags are cleared to 0. Reset abandons any presented word.
- Start sampled at edge e0 → `ram_addr`=first after e0 → `out_valid`=1 after edge e0+READ_LATENCY+1.
- With `out_ready` held high, each word occupies READ_LATENCY+2 cycles.
- N-word scan with `out_ready` high: `done` is high in cycle N·(READ_LATENCY+2), counted from e0 as cycle 0. `busy` drops on the following edge.
- Backpressure: each cycle of `out_ready`=0 in PRESENT adds one cycle. No word is lost or duplicated.

## Configuration
- `RAM_SCAN_READER_CHECKSUM_EN` defined: `checksum` accumulates as described.
- Undefined: no adder or accumulator register is built. `checksum` is tied to 0. All other behaviour and timing are identical.

## Structure
- Shared package: state encoding (IDLE/WAIT/PRESENT/DONE), default ADDR_W/DATA_W/READ_LATENCY constants, and the RAM depth constant 2^ADDR_W.
- One sub-module, `ram_scan_addr_ctr`: a loadable wrapping ADDR_W counter with a `last` compare output, used for `ram_addr`.

## Test plan
- Preload RAM[0..31]=addr×3. Start first=4, last=7, ready high → words 0x0C,0x0F,0x12,0x15 with out_addr 4..7, 3 cycles apart; `done` pulses in cycle 12; checksum=0x42.
- first=30, last=1 → addresses 30,31,0,1 in order; data 0x5A,0x5D,0x00,0x03; exactly 4 handshakes.
- first=last=9, ready low for 5 cycles after valid → `out_valid`/`out_data`=0x1B held stable all 5 cycles; single handshake; `done` one cycle later.
- Full scan 0..31, ready high → 32 words; checksum = Σ3i mod 256 = 0xD0; `done` in cycle 96.
- `start` re-pulsed mid-scan with first=0 → ignored, scan completes the original range. Then `resetn`=0 mid-PRESENT → all outputs 0 immediately; a new start scans correctly.
- Build without the macro → checksum stays 0 in every scenario above; data and timing unchanged.
